shell_fire_ctrl: RTL and testbench
==================================

# shell_fire_ctrl

Per-player fire controller that sits between the game logic's raw fire buttons and the two five-slot shell pools. It turns each button press into at most one single-cycle, one-hot fire pulse aimed at a free shell slot. Slots are chosen round-robin, and a per-player cooldown timer enforces a minimum spacing between shots. The block also keeps a saturating shot counter per player for the score/VGA overlay. The two players are fully independent; only clock, reset and `game_active` are shared.

## Interface
Parameters:
- `COOLDOWN`, default 2_000_000: cycles a player is blocked after a shot; legal range 1..2^24-1.
- `N_SLOT`, default 5: shell slots per player; legal range 2..8.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset: synchronous, active-low; clock `clk`
- `game_active`  in  1  1 = round in progress; 0 = hold idle and clear state
- `fire_btn_1` / `fire_btn_2`  in  1  player fire button, level, already synchronised/debounced
- `slot_free_1` / `slot_free_2`  in  N_SLOT  1 = slot idle and available (from shell pool)
- `fire_1` / `fire_2`  out  N_SLOT  one-hot fire pulse to shell pool, 1 cycle wide, registered
- `busy_1` / `busy_2`  out  1  1 = player in cooldown
- `shots_1` / `shots_2`  out  8  shots issued this round, saturating

## Operation
- Per player: button history flop `btn_q`. Rising edge = `fire_btn & ~btn_q`. `btn_q` updates every cycle, including during cooldown and while `game_active`=0.
- Per-player FSM, states READY and COOL.
  - READY: on a rising edge with `game_active`=1 and `|slot_free` = 1:
    - select slot, register the one-hot `fire`, increment `shots`;
    - load the cooldown counter with COOLDOWN-1; go to COOL.
  - READY, edge with no free slot: the press is dropped. Stay in READY; `ptr` and `shots` are unchanged.
  - COOL: the counter decrements each cycle. At 0, go to READY. Edges seen during COOL are dropped, not queued.
- Slot selection, per player:
  - rotate pointer `ptr` (width clog2(N_SLOT)); search `ptr`, `ptr+1`, … wrapping N_SLOT-1→0;
  - the first free slot wins;
  - after issuing slot k, `ptr` = (k+1) mod N_SLOT.
- `shots` saturates at 255, with no wrap.
- `game_active`=0, which takes priority over everything in the same cycle:
  - both FSMs go to READY; counters and `shots` cleared; `ptr` reset to 0;
  - `fire` forced to 0.
  - Presses arriving while `game_active`=0 never fire, even after `game_active` returns to 1, because the edge has already been consumed into `btn_q`.
- Both players may fire in the same cycle; they do not interact.
- Reset values: `fire_*`=0, `busy_*`=0, `shots_*`=0, FSMs READY, `ptr`=0, `btn_q`=0, cooldown counters 0.
- Reset mid-cooldown aborts the cooldown immediately. If the button is held through reset release, it fires on the next cycle after release, because `btn_q`=0.

## Timing
- Edge sampled at clock edge t → `fire_x` high for exactly cycle t+1, low at t+2.
- `busy_x` is high from cycle t+1 through t+COOLDOWN, i.e. exactly COOLDOWN cycles, and low at t+COOLDOWN+1.
- A rising edge sampled at t+COOLDOWN+1 fires at t+COOLDOWN+2. This gives a minimum shot spacing of COOLDOWN+1 cycles.
- A rising edge sampled while `busy_x`=1 is dropped.
- `slot_free` is sampled only in the decision cycle t. The pool drops that slot's free flag from t+1 (on the `fire` pulse). Cooldown ≥1 guarantees the stale flag is never re-sampled.
- `shots_x` updates at the same edge that raises `fire_x`.
- No combinational input→output paths.

## Test plan
Bench uses COOLDOWN=4, N_SLOT=5.
- Reset, then `game_active`=1, all slots free, press P1 at t:
  - `fire_1`=5'b00001 in cycle t+1 only;
  - `busy_1` high t+1..t+4;
  - `shots_1`=1.
- Round-robin, all slots free, five presses spaced 6 cycles apart → `fire_1` = 00001, 00010, 00100, 01000, 10000, then 00001 again.
- Slot availability:
  - `slot_free_1`=5'b10100 with `ptr`=0 → press gives 00100, and `ptr` becomes 3;
  - `slot_free_1`=0 → press produces no pulse; `busy_1`=0 and `shots_1` unchanged.
- Cooldown:
  - presses at t and t+2 → only one pulse;
  - presses at t and t+5 → pulses at t+1 and t+6.
- Simultaneous P1/P2 presses → both pulse in the same cycle with independent slots. Dropping `game_active` during P1 cooldown → `busy_1`=0, `shots_1`=0, `ptr` back to 0 the next cycle.
- Saturation and reset:
  - 260 spaced presses → `shots_1` stops at 255;
  - `rst_n`=0 mid-cooldown with button held → after release, `fire_1`=00001 one cycle later.

Source files
------------

// File: rtl/shell_fire_ctrl.sv
// Two-player fire controller: turns button presses into one-hot, single-cycle fire
// pulses aimed at free shell slots, with round-robin slot choice and a shot cooldown.

module shell_fire_player #(
  parameter int unsigned COOLDOWN = 2_000_000,
  parameter int unsigned N_SLOT   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_active,
  input  logic              fire_btn,
  input  logic [N_SLOT-1:0] slot_free,
  output logic [N_SLOT-1:0] fire,
  output logic              busy,
  output logic [7:0]        shots
);

  localparam int PW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam logic [23:0] CNT_LOAD = 24'(COOLDOWN - 1);

  typedef enum logic {READY, COOL} state_t;

  state_t            r_state, w_state_nxt;
  logic [23:0]       r_cnt, w_cnt_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [7:0]        r_shots, w_shots_nxt;
  logic [N_SLOT-1:0] r_fire, w_fire_nxt;
  logic              r_btn_q;
  logic              w_edge;
  logic              w_any_free;
  logic [PW-1:0]     w_sel;

  assign w_edge     = fire_btn & ~r_btn_q;
  assign w_any_free = |slot_free;

  // Scan from the highest offset down so the slot closest to r_ptr is the last writer.
  always_comb begin
    int j;
    logic [PW-1:0] w_idx;
    j     = 0;
    w_idx = '0;
    w_sel = '0;
    for (int i = int'(N_SLOT) - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= int'(N_SLOT)) j = j - int'(N_SLOT);
      w_idx = PW'(j);
      if (slot_free[w_idx]) w_sel = w_idx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_shots_nxt = r_shots;
    w_fire_nxt  = '0;
    if (!game_active) begin
      w_state_nxt = READY;
      w_cnt_nxt   = '0;
      w_ptr_nxt   = '0;
      w_shots_nxt = '0;
    end else begin
      unique case (r_state)
        READY: begin
          if (w_edge && w_any_free) begin
            w_fire_nxt[w_sel] = 1'b1;
            w_cnt_nxt         = CNT_LOAD;
            w_state_nxt       = COOL;
            w_ptr_nxt         = (w_sel == PW'(N_SLOT - 1)) ? '0 : w_sel + 1'b1;
            w_shots_nxt       = (r_shots == 8'hFF) ? r_shots : r_shots + 8'd1;
          end
        end
        COOL: begin
          if (r_cnt == '0) w_state_nxt = READY;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: w_state_nxt = READY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= READY;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_shots <= '0;
      r_fire  <= '0;
      r_btn_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_shots <= w_shots_nxt;
      r_fire  <= w_fire_nxt;
      r_btn_q <= fire_btn;
    end
  end

  assign fire  = r_fire;
  assign busy  = (r_state == COOL);
  assign shots = r_shots;

endmodule

module shell_fire_ctrl #(
  parameter int unsigned COOLDOWN = 2_000_000,
  parameter int unsigned N_SLOT   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_active,
  input  logic              fire_btn_1,
  input  logic              fire_btn_2,
  input  logic [N_SLOT-1:0] slot_free_1,
  input  logic [N_SLOT-1:0] slot_free_2,
  output logic [N_SLOT-1:0] fire_1,
  output logic [N_SLOT-1:0] fire_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic [7:0]        shots_1,
  output logic [7:0]        shots_2
);

  shell_fire_player #(.COOLDOWN(COOLDOWN), .N_SLOT(N_SLOT)) u_p1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_active(game_active),
    .fire_btn   (fire_btn_1),
    .slot_free  (slot_free_1),
    .fire       (fire_1),
    .busy       (busy_1),
    .shots      (shots_1)
  );

  shell_fire_player #(.COOLDOWN(COOLDOWN), .N_SLOT(N_SLOT)) u_p2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_active(game_active),
    .fire_btn   (fire_btn_2),
    .slot_free  (slot_free_2),
    .fire       (fire_2),
    .busy       (busy_2),
    .shots      (shots_2)
  );

endmodule

// File: tb/tb_shell_fire_ctrl.sv
// Bench for shell_fire_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_shell_fire_ctrl;

  localparam int COOL  = 4;
  localparam int N     = 5;
  localparam int NEVER = -1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_active;
  logic       fire_btn_1, fire_btn_2;
  logic [4:0] slot_free_1, slot_free_2;
  logic [4:0] fire_1, fire_2;
  logic       busy_1, busy_2;
  logic [7:0] shots_1, shots_2;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  shell_fire_ctrl #(.COOLDOWN(COOL), .N_SLOT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_active(game_active),
    .fire_btn_1 (fire_btn_1),
    .fire_btn_2 (fire_btn_2),
    .slot_free_1(slot_free_1),
    .slot_free_2(slot_free_2),
    .fire_1     (fire_1),
    .fire_2     (fire_2),
    .busy_1     (busy_1),
    .busy_2     (busy_2),
    .shots_1    (shots_1),
    .shots_2    (shots_2)
  );

  always #5 clk = ~clk;

  // Reference model: a shot is remembered by the edge index it was decided on;
  // busy and the next-allowed edge follow from that timestamp.
  int cyc = 0;
  int m_prev[2];
  int m_last[2];
  int m_ptr[2];
  int m_shots[2];
  int exp_fire[2];
  int exp_busy[2];
  int m_b, m_fr, m_k, m_idx;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int p = 0; p < 2; p++) begin
      m_b  = (p == 0) ? int'(fire_btn_1) : int'(fire_btn_2);
      m_fr = (p == 0) ? int'(slot_free_1) : int'(slot_free_2);
      exp_fire[p] = 0;
      if (!rst_n) begin
        m_prev[p]  = 0;
        m_last[p]  = NEVER;
        m_ptr[p]   = 0;
        m_shots[p] = 0;
      end else begin
        if (!game_active) begin
          m_last[p]  = NEVER;
          m_ptr[p]   = 0;
          m_shots[p] = 0;
        end else if (m_b == 1 && m_prev[p] == 0 && (cyc - 1) >= m_last[p] + COOL && m_fr != 0) begin
          m_k = -1;
          for (int off = 0; off < N; off++) begin
            m_idx = (m_ptr[p] + off) % N;
            if (m_k < 0 && ((m_fr >> m_idx) & 1) != 0) m_k = m_idx;
          end
          exp_fire[p] = 1 << m_k;
          m_ptr[p]    = (m_k + 1) % N;
          if (m_shots[p] < 255) m_shots[p] = m_shots[p] + 1;
          m_last[p]   = cyc;
        end
        m_prev[p] = m_b;
      end
      exp_busy[p] = (m_last[p] <= cyc && cyc < m_last[p] + COOL) ? 1 : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_fire_1",  32'(fire_1),  exp_fire[0]);
      check("model_busy_1",  32'(busy_1),  exp_busy[0]);
      check("model_shots_1", 32'(shots_1), m_shots[0]);
      check("model_fire_2",  32'(fire_2),  exp_fire[1]);
      check("model_busy_2",  32'(busy_2),  exp_busy[1]);
      check("model_shots_2", 32'(shots_2), m_shots[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit p1, input bit p2);
    if (p1) fire_btn_1 = 1'b1;
    if (p2) fire_btn_2 = 1'b1;
    @(negedge clk);
    fire_btn_1 = 1'b0;
    fire_btn_2 = 1'b0;
  endtask

  task automatic round_restart();
    game_active = 1'b0;
    tick(1);
    game_active = 1'b1;
    tick(1);
  endtask

  int rr[6] = '{1, 2, 4, 8, 16, 1};

  initial begin
    rst_n       = 1'b0;
    game_active = 1'b0;
    fire_btn_1  = 1'b0;
    fire_btn_2  = 1'b0;
    slot_free_1 = 5'h1F;
    slot_free_2 = 5'h1F;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_fire_1",  32'(fire_1),  0);
    check("reset_busy_1",  32'(busy_1),  0);
    check("reset_shots_1", 32'(shots_1), 0);
    tick(1);
    rst_n       = 1'b1;
    game_active = 1'b1;
    tick(2);

    // First shot: pulse for one cycle, busy for COOL cycles.
    press(1, 0);
    check("first_fire",  32'(fire_1),  5'b00001);
    check("first_busy",  32'(busy_1),  1);
    check("first_shots", 32'(shots_1), 1);
    tick(1);
    check("first_fire_gone", 32'(fire_1), 0);
    tick(2);
    check("busy_last_cycle", 32'(busy_1), 1);
    tick(1);
    check("busy_released", 32'(busy_1), 0);

    // Round-robin through all slots and wrap.
    round_restart();
    for (int i = 0; i < 6; i++) begin
      press(1, 0);
      check("round_robin", 32'(fire_1), 32'(rr[i]));
      tick(5);
    end

    // Slot availability.
    round_restart();
    slot_free_1 = 5'b10100;
    press(1, 0);
    check("sparse_slot", 32'(fire_1), 5'b00100);
    slot_free_1 = 5'h1F;
    tick(5);
    press(1, 0);
    check("ptr_after_sparse", 32'(fire_1), 5'b01000);
    tick(5);
    slot_free_1 = 5'b00000;
    press(1, 0);
    check("none_free_fire",  32'(fire_1),  0);
    check("none_free_busy",  32'(busy_1),  0);
    check("none_free_shots", 32'(shots_1), 2);
    slot_free_1 = 5'h1F;
    tick(5);

    // Cooldown: press during cooldown is dropped; press right after it fires.
    round_restart();
    press(1, 0);
    check("cool_first", 32'(fire_1), 5'b00001);
    tick(1);
    press(1, 0);
    check("cool_dropped", 32'(fire_1), 0);
    tick(5);
    check("cool_dropped_shots", 32'(shots_1), 1);
    round_restart();
    press(1, 0);
    check("spacing_first", 32'(fire_1), 5'b00001);
    tick(4);
    press(1, 0);
    check("spacing_second", 32'(fire_1), 5'b00010);
    tick(5);

    // Simultaneous players, then game_active drop mid-cooldown.
    round_restart();
    slot_free_2 = 5'b11000;
    press(1, 1);
    check("simul_fire_1", 32'(fire_1), 5'b00001);
    check("simul_fire_2", 32'(fire_2), 5'b01000);
    tick(1);
    game_active = 1'b0;
    tick(1);
    check("drop_busy_1",  32'(busy_1),  0);
    check("drop_shots_1", 32'(shots_1), 0);
    check("drop_busy_2",  32'(busy_2),  0);
    game_active = 1'b1;
    tick(1);
    press(1, 0);
    check("drop_ptr_zero", 32'(fire_1), 5'b00001);
    slot_free_2 = 5'h1F;
    tick(5);

    // Shot counter saturation.
    round_restart();
    for (int i = 0; i < 260; i++) begin
      press(1, (i % 3) == 0);
      tick(5);
    end
    check("shots_saturate", 32'(shots_1), 255);
    check("shots_p2",       32'(shots_2), 87);

    // Reset mid-cooldown with the button held through release.
    press(1, 0);
    fire_btn_1 = 1'b1;
    rst_n      = 1'b0;
    tick(2);
    check("rst_busy",  32'(busy_1),  0);
    check("rst_shots", 32'(shots_1), 0);
    rst_n = 1'b1;
    tick(1);
    check("held_after_reset", 32'(fire_1), 5'b00001);
    fire_btn_1 = 1'b0;
    tick(6);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
